div_unit: RTL and testbench

- Iterative restoring divider that serves the execute stage for div.w / mod.w / div.wu / mod.wu.
- The execute stage is the initiator: it raises a start request, holds its pause request while busy_o is high, and captures quotient and remainder on done_o.
- The block returns both quotient and remainder. The execute stage picks one by aluop.
- It sits beside the ALU inside the back-end execute stage and is cancelled by pipeline flush.

---
 rtl/div_unit.sv | 179 +++++++++++++++++
 tb/tb_div_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative restoring divider for div.w / mod.w / div.wu / mod.wu
//
// One restoring step per cycle on operand magnitudes. Sign fixups are applied
// on the last step, so both results are ready when done_o pulses. Nonzero
// divisors finish WIDTH+1 cycles after the start edge. A zero divisor finishes
// after 2 cycles with quotient = all ones and remainder = raw dividend.
//
// Optional build macro: DIV_FAST_SMALL_EN
//   When defined, an operation with |dividend| < |divisor| (divisor nonzero)
//   takes a 2-cycle shortcut: quotient = 0, remainder = raw dividend.
//   When undefined, such operations run the full iteration and give the same
//   numeric result.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      division request, sampled only in IDLE
//   signed_i     1 = signed operation, sampled with start_i
//   dividend_i   dividend, sampled with start_i
//   divisor_i    divisor, sampled with start_i
//   annul_i      flush: abandons any operation in progress (wins over start_i)
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse; results valid during this cycle
//   quotient_o   quotient while done_o = 1, otherwise 0
//   remainder_o  remainder while done_o = 1, otherwise 0
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ON       = 3'd1,
    ST_DIV_ZERO = 3'd2,
    ST_FAST     = 3'd3,
    ST_END      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, final remainder in END
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic             negq_q, negq_d; // operand signs differ
  logic             negr_q, negr_d; // dividend negative

  // Operand magnitudes at the start edge
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = signed_i & dividend_i[WIDTH-1];
    b_neg = signed_i & divisor_i[WIDTH-1];
    a_mag = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  end

  // Restoring step. The shifted partial remainder can need WIDTH+1 bits for
  // unsigned divisors above 2^(WIDTH-1); one extra bit catches the borrow.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH+1:0] rem_full;
  logic             borrow;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             unused_bits;

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs_q};
    borrow   = diff[WIDTH+1];
    // After either choice the value is below the divisor and fits WIDTH bits
    rem_full = borrow ? {1'b0, shifted} : diff;
    rem_step = rem_full[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ~borrow};
  end

  assign unused_bits = ^rem_full[WIDTH+1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            quo_d   = '1;
            rem_d   = dividend_i;
            state_d = ST_DIV_ZERO;
          end
`ifdef DIV_FAST_SMALL_EN
          else if (a_mag < b_mag) begin
            quo_d   = '0;
            rem_d   = dividend_i;
            state_d = ST_FAST;
          end
`endif
          else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = '0;
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last step: apply sign fixups so END presents final values
          quo_d   = negq_q ? (~quo_step + 1'b1) : quo_step;
          rem_d   = negr_q ? (~rem_step + 1'b1) : rem_step;
          cnt_d   = '0;
          state_d = ST_END;
        end
      end
      ST_DIV_ZERO: state_d = ST_END;
      ST_FAST:     state_d = ST_END;
      ST_END:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including a start in IDLE
    if (annul_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_END);
  assign quotient_o  = done_o ? quo_q : '0;
  assign remainder_o = done_o ? rem_q : '0;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic         signed_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         annul_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .annul_i     (annul_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

`ifdef DIV_FAST_SMALL_EN
  localparam int SMALL_LAT = 2;
`else
  localparam int SMALL_LAT = 33;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives a start, scrambles the operands after the
  // start edge, waits (bounded) for done_o and checks latency, busy cycles,
  // results and the return to idle.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input int elat);
    int  cyc;
    int  busy_cyc;
    logic got;
    signed_i   = sg;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(posedge clk);
    cyc = 0; busy_cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy_o) busy_cyc++;
      if (cyc == 1) begin
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
      end
      if (done_o) got = 1'b1;
    end
    check({tag, "_lat"},  cyc, elat);
    check({tag, "_busy"}, busy_cyc, elat);
    check({tag, "_q"},    quotient_o, eq);
    check({tag, "_r"},    remainder_o, er);
    $display("txn %s: a=0x%08h b=0x%08h s=%0d -> q=0x%08h r=0x%08h in %0d cycles",
             tag, a, b, sg, quotient_o, remainder_o, cyc);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy_o, 1'b0);
    check({tag, "_idle_done"}, done_o, 1'b0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0;
    dividend_i = '0; divisor_i = '0; annul_i = 1'b0;
    #13;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_q", quotient_o, 32'h0);
    check("rst_r", remainder_o, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_div("u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33);
    run_div("s-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  33);
    run_div("s7_-2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         33);
    run_div("smin_-1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         33);
    run_div("uffff_2",  1'b0, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  32'd1,         33);
    run_div("s-1_2",    1'b1, 32'hFFFFFFFF,  32'd2,         32'h0,         32'hFFFFFFFF,  SMALL_LAT);
    run_div("s-5_0",    1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB,  2);

    // Divide by zero with start held through busy and END: one done only
    d0 = done_cnt;
    signed_i = 1'b0; dividend_i = 32'd5; divisor_i = 32'd0; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("dz_c1_busy", busy_o, 1'b1);
    check("dz_c1_done", done_o, 1'b0);
    @(negedge clk);
    check("dz_c2_done", done_o, 1'b1);
    check("dz_q", quotient_o, 32'hFFFFFFFF);
    check("dz_r", remainder_o, 32'd5);
    @(negedge clk);
    start_i = 1'b0;
    check("dz_end_start_ignored", busy_o, 1'b0);
    repeat (3) @(negedge clk);
    check("dz_one_pulse", done_cnt - d0, 1);
    $display("txn dz: 5/0 held start, done pulses=%0d", done_cnt - d0);

    // Annul in cycle 10 of a 100/7 run, then 9/3 starting in cycle 11
    d0 = done_cnt;
    signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
    end
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("ann_c11_busy", busy_o, 1'b0);
    check("ann_no_done", done_cnt - d0, 0);
    $display("txn annul: 100/7 flushed at cycle 10");
    run_div("ann_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Annul and start together in IDLE: nothing starts
    dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("ann_start_busy", busy_o, 1'b0);
    $display("txn annul+start: busy=%0d", busy_o);

    // Async reset while done_o is high
    signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
    end
    check("rstmid_pre_done", done_o, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy_o, 1'b0);
    check("rstmid_done", done_o, 1'b0);
    check("rstmid_q", quotient_o, 32'h0);
    check("rstmid_r", remainder_o, 32'h0);
    $display("txn reset: asserted during END");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_div("u3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, SMALL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
